// File: rtl/idu_pipe_stage_ysyx_23060136.sv
// Decode stage between IFU and EXU: operand fetch with WB bypass, per-register
// pending-write counters for RAW stalls, and a single output pipeline register.
module idu_pipe_stage_ysyx_23060136 #(
  parameter int XLEN   = 32,
  parameter int NR_GPR = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IDU_i_valid,
  output logic            IDU_o_ready,
  input  logic [XLEN-1:0] IDU_i_pc,
  input  logic [31:0]     IDU_i_inst,
  input  logic            IDU_i_flush,
  output logic            IDU_o_valid,
  input  logic            EXU_i_ready,
  output logic [XLEN-1:0] IDU_o_pc,
  output logic [31:0]     IDU_o_inst,
  output logic [4:0]      IDU_o_rd,
  output logic            IDU_o_write_gpr,
  output logic [XLEN-1:0] IDU_o_rs1_data,
  output logic [XLEN-1:0] IDU_o_rs2_data,
  input  logic [4:0]      WB_o_rd,
  input  logic            WB_o_RegWr,
  input  logic [XLEN-1:0] WB_o_rf_busW
);

  localparam int IDX_W = $clog2(NR_GPR);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic rd;
    logic rs1;
    logic rs2;
  } use_t;

  function automatic use_t decode_use(input logic [31:0] inst);
    use_t u;
    u = '{rd: 1'b0, rs1: 1'b0, rs2: 1'b0};
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL:     u = '{rd: 1'b1, rs1: 1'b0, rs2: 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM:   u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b0};
      OPC_BRANCH, OPC_STORE:           u = '{rd: 1'b0, rs1: 1'b1, rs2: 1'b1};
      OPC_OP:                          u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b1};
      OPC_SYSTEM: begin
        u.rd  = (inst[14:12] != 3'b000);
        u.rs1 = (inst[14:12] != 3'b000);
        u.rs2 = 1'b0;
      end
      default:                         u = '{rd: 1'b0, rs1: 1'b0, rs2: 1'b0};
    endcase
    return u;
  endfunction

  // A pending write retiring this very cycle (last outstanding one) no longer blocks the read.
  function automatic logic rs_hazard(input logic used, input logic nonzero, input logic out_match,
                                     input logic [PEND_W-1:0] pend, input logic wb_hit);
    return used & nonzero & (out_match | ((pend != PEND_ZERO) & !(wb_hit & (pend == PEND_ONE))));
  endfunction

  logic              out_valid_r;
  logic [XLEN-1:0]   pc_r;
  logic [31:0]       inst_r;
  logic [4:0]        rd_r;
  logic              write_gpr_r;
  logic [XLEN-1:0]   rs1_data_r;
  logic [XLEN-1:0]   rs2_data_r;
  logic [XLEN-1:0]   gpr_r     [NR_GPR];
  logic [PEND_W-1:0] pending_r [NR_GPR];
  logic [PEND_W-1:0] pending_nxt_s [NR_GPR];

  use_t            use_s;
  logic [IDX_W-1:0] rs1_idx_s;
  logic [IDX_W-1:0] rs2_idx_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wb_idx_s;
  logic [IDX_W-1:0] out_rd_idx_s;
  logic            wb_we_s;
  logic            hazard_s;
  logic            hold_full_s;
  logic            out_valid_s;
  logic            fire_s;
  logic            slot_free_s;
  logic            ready_s;
  logic            accept_s;
  logic            write_gpr_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

  // Field extraction, hazard detection and handshake control.
  always_comb begin
    use_s        = decode_use(IDU_i_inst);
    rs1_idx_s    = IDU_i_inst[15 +: IDX_W];
    rs2_idx_s    = IDU_i_inst[20 +: IDX_W];
    rd_idx_s     = IDU_i_inst[7 +: IDX_W];
    wb_idx_s     = WB_o_rd[IDX_W-1:0];
    out_rd_idx_s = rd_r[IDX_W-1:0];
    wb_we_s      = WB_o_RegWr & (wb_idx_s != IDX_ZERO);
    write_gpr_s  = use_s.rd & (rd_idx_s != IDX_ZERO);

    hazard_s = rs_hazard(use_s.rs1, rs1_idx_s != IDX_ZERO,
                         out_valid_r & write_gpr_r & (out_rd_idx_s == rs1_idx_s),
                         pending_r[rs1_idx_s], wb_we_s & (wb_idx_s == rs1_idx_s))
             | rs_hazard(use_s.rs2, rs2_idx_s != IDX_ZERO,
                         out_valid_r & write_gpr_r & (out_rd_idx_s == rs2_idx_s),
                         pending_r[rs2_idx_s], wb_we_s & (wb_idx_s == rs2_idx_s));

    // Issuing would overflow the destination counter unless a writeback frees a slot now.
    hold_full_s = write_gpr_r & (pending_r[out_rd_idx_s] == PEND_MAX)
                & !(wb_we_s & (wb_idx_s == out_rd_idx_s));
    out_valid_s = out_valid_r & !hold_full_s;
    fire_s      = out_valid_s & EXU_i_ready;
    slot_free_s = !out_valid_r | fire_s;
    ready_s     = slot_free_s & !hazard_s & !IDU_i_flush;
    accept_s    = IDU_i_valid & ready_s;
  end

  // Operand read with same-cycle writeback bypass; unused or x0 operands read as zero.
  always_comb begin
    rs1_val_s = {XLEN{1'b0}};
    rs2_val_s = {XLEN{1'b0}};
    if (use_s.rs1 && (rs1_idx_s != IDX_ZERO)) begin
      if (wb_we_s && (wb_idx_s == rs1_idx_s)) rs1_val_s = WB_o_rf_busW;
      else                                     rs1_val_s = gpr_r[rs1_idx_s];
    end else begin
      rs1_val_s = {XLEN{1'b0}};
    end
    if (use_s.rs2 && (rs2_idx_s != IDX_ZERO)) begin
      if (wb_we_s && (wb_idx_s == rs2_idx_s)) rs2_val_s = WB_o_rf_busW;
      else                                     rs2_val_s = gpr_r[rs2_idx_s];
    end else begin
      rs2_val_s = {XLEN{1'b0}};
    end
  end

  // Next pending count per register; an issue and a retire on the same register cancel out.
  always_comb begin
    for (int i = 0; i < NR_GPR; i++) begin
      case ({fire_s & write_gpr_r & (out_rd_idx_s == IDX_W'(i)),
             wb_we_s & (wb_idx_s == IDX_W'(i)) & (pending_r[i] != PEND_ZERO)})
        2'b10:   pending_nxt_s[i] = pending_r[i] + PEND_ONE;
        2'b01:   pending_nxt_s[i] = pending_r[i] - PEND_ONE;
        default: pending_nxt_s[i] = pending_r[i];
      endcase
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      pc_r        <= {XLEN{1'b0}};
      inst_r      <= 32'h0000_0000;
      rd_r        <= 5'd0;
      write_gpr_r <= 1'b0;
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      pc_r        <= IDU_i_pc;
      inst_r      <= IDU_i_inst;
      rd_r        <= IDU_i_inst[11:7];
      write_gpr_r <= write_gpr_s;
      rs1_data_r  <= rs1_val_s;
      rs2_data_r  <= rs2_val_s;
    end else if (fire_s || IDU_i_flush) begin
      out_valid_r <= 1'b0;
    end
  end

  // Register file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++) gpr_r[i] <= {XLEN{1'b0}};
    end else if (wb_we_s) begin
      gpr_r[wb_idx_s] <= WB_o_rf_busW;
    end
  end

  // Pending-write scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++) pending_r[i] <= PEND_ZERO;
    end else begin
      for (int i = 0; i < NR_GPR; i++) pending_r[i] <= pending_nxt_s[i];
    end
  end

  assign IDU_o_ready     = ready_s;
  assign IDU_o_valid     = out_valid_s;
  assign IDU_o_pc        = pc_r;
  assign IDU_o_inst      = inst_r;
  assign IDU_o_rd        = rd_r;
  assign IDU_o_write_gpr = write_gpr_r;
  assign IDU_o_rs1_data  = rs1_data_r;
  assign IDU_o_rs2_data  = rs2_data_r;

endmodule

// File: tb/tb_idu_pipe_stage_ysyx_23060136.sv
// Directed bench for the decode stage; issued instructions are queued as expected
// issue records and a negedge monitor compares them whenever the stage fires.
module tb_idu_pipe_stage_ysyx_23060136;

  logic        clk = 1'b0;
  logic        rst;
  logic        IDU_i_valid;
  logic        IDU_o_ready;
  logic [31:0] IDU_i_pc;
  logic [31:0] IDU_i_inst;
  logic        IDU_i_flush;
  logic        IDU_o_valid;
  logic        EXU_i_ready;
  logic [31:0] IDU_o_pc;
  logic [31:0] IDU_o_inst;
  logic [4:0]  IDU_o_rd;
  logic        IDU_o_write_gpr;
  logic [31:0] IDU_o_rs1_data;
  logic [31:0] IDU_o_rs2_data;
  logic [4:0]  WB_o_rd;
  logic        WB_o_RegWr;
  logic [31:0] WB_o_rf_busW;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wg;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  idu_pipe_stage_ysyx_23060136 dut (
    .clk(clk), .rst(rst),
    .IDU_i_valid(IDU_i_valid), .IDU_o_ready(IDU_o_ready),
    .IDU_i_pc(IDU_i_pc), .IDU_i_inst(IDU_i_inst), .IDU_i_flush(IDU_i_flush),
    .IDU_o_valid(IDU_o_valid), .EXU_i_ready(EXU_i_ready),
    .IDU_o_pc(IDU_o_pc), .IDU_o_inst(IDU_o_inst), .IDU_o_rd(IDU_o_rd),
    .IDU_o_write_gpr(IDU_o_write_gpr),
    .IDU_o_rs1_data(IDU_o_rs1_data), .IDU_o_rs2_data(IDU_o_rs2_data),
    .WB_o_rd(WB_o_rd), .WB_o_RegWr(WB_o_RegWr), .WB_o_rf_busW(WB_o_rf_busW)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                      input logic wg, input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    e.pc = pc; e.inst = inst; e.rd = rd; e.wg = wg; e.rs1 = rs1; e.rs2 = rs2;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    WB_o_RegWr = en; WB_o_rd = rd; WB_o_rf_busW = data;
  endtask

  // Offer one instruction and wait (bounded) until the stage takes it.
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    int n;
    n = 0;
    IDU_i_valid = 1'b1; IDU_i_pc = pc; IDU_i_inst = inst;
    @(negedge clk);
    while (IDU_o_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (IDU_o_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL offer_timeout: pc 0x%08h got ready=%b expected 1", pc, IDU_o_ready);
    end
    tick();
    IDU_i_valid = 1'b0;
  endtask

  // Scoreboard monitor: every issue to EXU must match the oldest expected record.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && IDU_o_valid === 1'b1 && EXU_i_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected: got issue of pc 0x%08h expected none", IDU_o_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", IDU_o_pc, e.pc);
        chk("sb_inst", IDU_o_inst, e.inst);
        chk("sb_rd", {27'd0, IDU_o_rd}, {27'd0, e.rd});
        chk("sb_write_gpr", {31'd0, IDU_o_write_gpr}, {31'd0, e.wg});
        chk("sb_rs1_data", IDU_o_rs1_data, e.rs1);
        chk("sb_rs2_data", IDU_o_rs2_data, e.rs2);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; IDU_i_valid = 1'b0; IDU_i_pc = 32'd0; IDU_i_inst = 32'd0;
    IDU_i_flush = 1'b0; EXU_i_ready = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_valid", {31'd0, IDU_o_valid}, 32'd0);
    chk("rst_pc", IDU_o_pc, 32'd0);
    chk("rst_rd", {27'd0, IDU_o_rd}, 32'd0);
    chk("rst_rs1", IDU_o_rs1_data, 32'd0);
    chk("rst_ready", {31'd0, IDU_o_ready}, 32'd1);
    tick();

    // addi x1,x0,5 held with EXU stalled
    IDU_i_valid = 1'b1; IDU_i_pc = 32'h100; IDU_i_inst = 32'h0050_0093;
    @(negedge clk);
    chk("addi_ready", {31'd0, IDU_o_ready}, 32'd1);
    tick();
    IDU_i_valid = 1'b0;
    push(32'h100, 32'h0050_0093, 5'd1, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    chk("addi_valid", {31'd0, IDU_o_valid}, 32'd1);
    chk("addi_rd", {27'd0, IDU_o_rd}, 32'd1);
    chk("addi_wg", {31'd0, IDU_o_write_gpr}, 32'd1);
    chk("addi_rs1", IDU_o_rs1_data, 32'd0);
    tick();

    // add x2,x1,x1 stalls until WB x1=5, accepted with bypassed operands
    EXU_i_ready = 1'b1;
    IDU_i_valid = 1'b1; IDU_i_pc = 32'h104; IDU_i_inst = 32'h0010_8133;
    @(negedge clk);
    chk("raw_out_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("raw_pend_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    wb(1'b1, 5'd1, 32'd5);
    @(negedge clk);
    chk("raw_wb_ready", {31'd0, IDU_o_ready}, 32'd1);
    tick();
    push(32'h104, 32'h0010_8133, 5'd2, 1'b1, 32'd5, 32'd5);
    wb(1'b0, 5'd0, 32'd0);
    IDU_i_valid = 1'b0;
    tick();
    wb(1'b1, 5'd2, 32'd10);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // sw x3,0(x0) with same-cycle WB x3 bypass, then sw x2,0(x3) reading the file
    wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    offer(32'h108, 32'h0030_2023);
    wb(1'b0, 5'd0, 32'd0);
    push(32'h108, 32'h0030_2023, 5'd0, 1'b0, 32'd0, 32'hDEAD_BEEF);
    offer(32'h10C, 32'h0021_A023);
    push(32'h10C, 32'h0021_A023, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'd10);

    // four writes to x4: the fourth holds at the counter limit
    for (int k = 0; k < 4; k++) begin
      offer(32'h200 + 32'(4 * k), 32'h0010_0213);
      push(32'h200 + 32'(4 * k), 32'h0010_0213, 5'd4, 1'b1, 32'd0, 32'd0);
    end
    @(negedge clk);
    chk("sat_valid", {31'd0, IDU_o_valid}, 32'd0);
    chk("sat_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("sat_valid_hold", {31'd0, IDU_o_valid}, 32'd0);
    tick();
    wb(1'b1, 5'd4, 32'h11);
    @(negedge clk);
    chk("sat_wb_valid", {31'd0, IDU_o_valid}, 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("sat_after_fire", {31'd0, IDU_o_valid}, 32'd0);

    // counter stayed at 3: addi x6,x4,0 needs three retirements of x4
    tick();
    IDU_i_valid = 1'b1; IDU_i_pc = 32'h210; IDU_i_inst = 32'h0002_0313;
    wb(1'b1, 5'd4, 32'h22);
    @(negedge clk);
    chk("cnt3_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    wb(1'b1, 5'd4, 32'h33);
    @(negedge clk);
    chk("cnt2_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("cnt1_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    wb(1'b1, 5'd4, 32'h44);
    @(negedge clk);
    chk("cnt1_wb_ready", {31'd0, IDU_o_ready}, 32'd1);
    tick();
    push(32'h210, 32'h0002_0313, 5'd6, 1'b1, 32'h44, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    IDU_i_valid = 1'b0;
    tick();

    // flush of a held lui x7 does not count toward pending[7]
    EXU_i_ready = 1'b0;
    offer(32'h300, 32'h1234_53B7);
    @(negedge clk);
    chk("hold_valid", {31'd0, IDU_o_valid}, 32'd1);
    chk("hold_pc", IDU_o_pc, 32'h300);
    tick();
    @(negedge clk);
    chk("hold_pc_stable", IDU_o_pc, 32'h300);
    tick();
    IDU_i_flush = 1'b1;
    IDU_i_valid = 1'b1; IDU_i_pc = 32'h304; IDU_i_inst = 32'h0003_8413;
    @(negedge clk);
    chk("flush_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    IDU_i_flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, IDU_o_valid}, 32'd0);
    chk("flush_ready_after", {31'd0, IDU_o_ready}, 32'd1);
    tick();
    push(32'h304, 32'h0003_8413, 5'd8, 1'b1, 32'd0, 32'd0);
    IDU_i_valid = 1'b0;
    tick();
    EXU_i_ready = 1'b1;

    // two writes to x5 in flight, dependent add stalls, then reset mid-stall
    offer(32'h308, 32'h0010_0293);
    push(32'h308, 32'h0010_0293, 5'd5, 1'b1, 32'd0, 32'd0);
    offer(32'h30C, 32'h0010_0293);
    push(32'h30C, 32'h0010_0293, 5'd5, 1'b1, 32'd0, 32'd0);
    IDU_i_valid = 1'b1; IDU_i_pc = 32'h310; IDU_i_inst = 32'h0042_84B3;
    @(negedge clk);
    chk("x5_out_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("x5_pend_ready", {31'd0, IDU_o_ready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_valid", {31'd0, IDU_o_valid}, 32'd0);
    chk("rst2_pc", IDU_o_pc, 32'd0);
    chk("rst2_rd", {27'd0, IDU_o_rd}, 32'd0);
    chk("rst2_ready", {31'd0, IDU_o_ready}, 32'd1);
    tick();
    push(32'h310, 32'h0042_84B3, 5'd9, 1'b1, 32'd0, 32'd0);
    IDU_i_valid = 1'b0;
    @(negedge clk);
    chk("rst2_fire_valid", {31'd0, IDU_o_valid}, 32'd1);
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
